// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment scan multiplexer.
//   DIGIT_W     width of one BCD digit code
//   BLANK_CODE  code that the downstream decoder renders as all segments off
//   MAX_DIGITS  largest supported digit count; sizes the lz_mask word and result
//   lz_mask()   per-digit vector, bit i set when digit i is a leading zero
package seven_seg_pkg;

   localparam int         DIGIT_W    = 4;
   localparam logic [3:0] BLANK_CODE = 4'hF;
   localparam int         MAX_DIGITS = 8;

   // Walks from the most significant used digit downwards. A digit stays
   // blankable until a non-zero digit (BCD or not) has been seen at or above it.
   // Digit 0 is never reported, so a zero word still shows a single 0.
   function automatic logic [MAX_DIGITS-1:0] lz_mask(
      input logic [DIGIT_W*MAX_DIGITS-1:0] word,
      input int                            n
   );
      logic [MAX_DIGITS-1:0] mask;
      logic                  seen;
      mask = '0;
      seen = 1'b0;
      for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
         if (i < n) begin
            seen    = seen | (word[i*DIGIT_W +: DIGIT_W] != '0);
            mask[i] = ~seen;
         end
      end
      return mask;
   endfunction

endpackage

// File: rtl/seven_segment_scan_mux_if.sv
// Load handshake between a word producer and the scan multiplexer.
//   load_valid  producer -> mux   load_data is valid
//   load_ready  mux -> producer   pending buffer empty, a load can be accepted
//   load_data   producer -> mux   packed BCD word, digit 0 in bits [3:0]
// Modports: master = producer side, slave = scan multiplexer side.
interface seven_segment_scan_mux_if #(
   parameter int NUM_DIGITS = 4
);
   import seven_seg_pkg::*;

   logic                          load_valid;
   logic                          load_ready;
   logic [DIGIT_W*NUM_DIGITS-1:0] load_data;

   modport master (output load_valid, output load_data, input load_ready);
   modport slave  (input load_valid, input load_data, output load_ready);

endinterface

// File: rtl/seven_seg_slot_timer.sv
// Slot and digit sequencer for the scan multiplexer.
//   clk, rst_n   clock, asynchronous active-low reset
//   cnt          position inside the current slot, 0..PRESCALE-1
//   digit_idx    digit being scanned, 0..NUM_DIGITS-1, LS digit first
//   in_dead      high during the first BLANK_CYCLES cycles of every slot
//   frame_tick   high in the last cycle of the last slot of a frame
module seven_seg_slot_timer #(
   parameter  int PRESCALE     = 50000,
   parameter  int BLANK_CYCLES = 16,
   parameter  int NUM_DIGITS   = 4,
   localparam int CNT_W        = $clog2(PRESCALE),
   localparam int IDX_W        = $clog2(NUM_DIGITS)
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [CNT_W-1:0] cnt,
   output logic [IDX_W-1:0] digit_idx,
   output logic             in_dead,
   output logic             frame_tick
);

   logic slot_end;

   assign slot_end   = (cnt == CNT_W'(PRESCALE - 1));
   assign frame_tick = slot_end && (digit_idx == IDX_W'(NUM_DIGITS - 1));

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         digit_idx <= '0;
      end else if (slot_end) begin
         cnt <= '0;
         if (digit_idx == IDX_W'(NUM_DIGITS - 1)) digit_idx <= '0;
         else                                     digit_idx <= digit_idx + IDX_W'(1);
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Without dead time the compare would be constant-false; tie it off instead.
   generate
      if (BLANK_CYCLES == 0) begin : g_no_dead
         assign in_dead = 1'b0;
      end else begin : g_dead
         assign in_dead = (cnt < CNT_W'(BLANK_CYCLES));
      end
   endgenerate

endmodule

// File: rtl/seven_segment_scan_mux.sv
// Time-multiplexed scan driver for a NUM_DIGITS-digit seven-segment display.
//   clk, rst_n   clock, asynchronous active-low reset
//   load         slave side of the load handshake (valid/ready/data)
//   digit_bin    4-bit code to the binary-to-seven-segment decoder, F = blank
//   digit_en     one-hot active-high digit enable, all-zero in dead time
// A loaded word waits in pending and moves to display only at a frame
// boundary, so one frame never shows digits of two different words.
// Outputs are registered: they reflect the slot state of the previous cycle.
module seven_segment_scan_mux
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 16,
   parameter int LZ_BLANK     = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   seven_segment_scan_mux_if.slave      load,
   output logic [DIGIT_W-1:0]           digit_bin,
   output logic [NUM_DIGITS-1:0]        digit_en
);

   localparam int WORD_W = DIGIT_W * NUM_DIGITS;
   localparam int CNT_W  = $clog2(PRESCALE);
   localparam int IDX_W  = $clog2(NUM_DIGITS);

   localparam logic [0:0] ST_DEAD = 1'b0;
   localparam logic [0:0] ST_SHOW = 1'b1;

   logic [CNT_W-1:0]            slot_cnt;
   logic [IDX_W-1:0]            digit_idx;
   logic                        in_dead;
   logic                        frame_tick;
   logic [0:0]                  slot_state;

   logic [WORD_W-1:0]           pending_word;
   logic [WORD_W-1:0]           display_reg;
   logic                        pending_full;
   logic                        accept;

   logic [DIGIT_W*MAX_DIGITS-1:0] display_wide;
   logic [MAX_DIGITS-1:0]         lz_vec;
   logic                          blanked;
   logic [DIGIT_W-1:0]            next_bin;
   logic [NUM_DIGITS-1:0]         next_en;

   seven_seg_slot_timer #(
      .PRESCALE     (PRESCALE),
      .BLANK_CYCLES (BLANK_CYCLES),
      .NUM_DIGITS   (NUM_DIGITS)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .cnt        (slot_cnt),
      .digit_idx  (digit_idx),
      .in_dead    (in_dead),
      .frame_tick (frame_tick)
   );

   // The two-state per-slot FSM is fully decoded from the slot counter.
   assign slot_state = in_dead ? ST_DEAD : ST_SHOW;

   // ---------------- load handshake / double buffer ----------------
   // Accept is only possible with pending empty, so it can never collide with
   // the pending -> display transfer; a word accepted on the boundary cycle
   // waits for the next boundary.
   assign accept          = load.load_valid && !pending_full;
   assign load.load_ready = !pending_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_word <= '0;
         display_reg  <= '0;
         pending_full <= 1'b0;
      end else if (accept) begin
         pending_word <= load.load_data;
         pending_full <= 1'b1;
      end else if (frame_tick && pending_full) begin
         display_reg  <= pending_word;
         pending_full <= 1'b0;
      end
   end

   // ---------------- blanking and output selection ----------------
   // NOTE: every always_comb output gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      display_wide                = '0;
      display_wide[WORD_W-1:0]    = display_reg;
   end

   assign lz_vec  = lz_mask(display_wide, NUM_DIGITS);
   assign blanked = (LZ_BLANK != 0) && lz_vec[digit_idx];

   always_comb begin
      next_bin = BLANK_CODE;
      next_en  = '0;
      if (slot_state == ST_SHOW && !blanked) begin
         next_bin = display_reg[digit_idx*DIGIT_W +: DIGIT_W];
         next_en  = NUM_DIGITS'(1) << digit_idx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_bin <= BLANK_CODE;
         digit_en  <= '0;
      end else begin
         digit_bin <= next_bin;
         digit_en  <= next_en;
      end
   end

   // The frame boundary must coincide with the last count of a slot.
   frame_tick_at_slot_end : assert property (
      @(posedge clk) disable iff (!rst_n)
      frame_tick |-> (slot_cnt == CNT_W'(PRESCALE - 1))
   );

endmodule
